meta_parser: RTL and testbench
==============================

# meta_parser

Receive-side decoder for the SUMP/OLS metadata stream: consumes the byte sequence that answers a metadata query (command 0x04) and turns it into tokens plus a captured register set. It sits behind the byte receiver in loopback/self-test builds and in a bridge FPGA talking to a downstream analyzer core. It provides the read side of the metadata transmitter and validates every type byte, string terminator and numeric length.

## Interface
- MAX_STR_LEN, 64: maximum string payload bytes per string token, terminator excluded; range 1..255.
- clock  in  1  system clock, all logic on rising edge.
- extReset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; clears results and arms the parser.
- rx_valid  in  1  one-cycle strobe, rx_data is valid.
- rx_data  in  8  received metadata byte.
- busy  out  1  parser armed and not finished.
- str_valid  out  1  pulse: str_byte valid.
- str_key  out  8  type byte of the current string token.
- str_byte  out  8  string payload byte; 0x00 on the terminator pulse.
- str_last  out  1  with str_valid, marks the terminator.
- num_valid  out  1  pulse: numeric token complete.
- num_key  out  8  type byte of the numeric token.
- num_value  out  32  value: zero-extended for short tokens.
- meta_sample_mem  out  32  last value for key 0x21.
- meta_max_rate  out  32  last value for key 0x23.
- meta_probes  out  8  last value for key 0x40.
- meta_protocol  out  8  last value for key 0x41.
- meta_done  out  1  end-of-data 0x00 received; held.
- meta_error  out  1  malformed stream; held.

## Operation
- States: IDLE, KEY, STRING, LONG, SHORT, DONE, ERROR. Reset -> IDLE.
- IDLE: ignores rx_valid. start -> KEY; clears meta_* registers, meta_done, meta_error.
- KEY, on an accepted byte b, branches as follows:
  - b==0x00 -> DONE.
  - 0x01..0x1F -> STRING.
  - 0x20..0x3F -> LONG, byte count 0.
  - 0x40..0x5F -> SHORT.
  - 0x60..0xFF -> ERROR.
  - In every case except ERROR, the key is latched.
- STRING: each byte pulses str_valid with str_key and str_byte.
  - Byte 0x00: str_last=1 -> KEY.
  - Non-zero payload byte while the length counter already equals MAX_STR_LEN -> ERROR, with no str_valid for that byte.
- LONG: collects 4 bytes MSB first into a 32-bit shift register. After the 4th byte, pulses num_valid -> KEY.
- SHORT: one byte; pulses num_valid with num_value={24'h0,b} -> KEY.
- Numeric capture: key 0x21/0x23/0x40/0x41 also updates the matching meta_* register, on the same edge as the num_valid pulse. Other keys produce only the pulse.
- DONE and ERROR: meta_done / meta_error held high, rx_valid ignored; leave only via start.
- busy=1 in KEY, STRING, LONG, SHORT.
- start in any state aborts the current token and re-arms: counters are cleared, and no partial token is emitted.
- start and rx_valid in the same cycle: start wins and the byte is dropped.

## Timing
- Reset values: every output 0, state IDLE.
- Every output is registered. Token pulses are exactly 1 cycle high, the cycle after the edge that accepts the completing byte.
- One byte per cycle is sustained: back-to-back rx_valid is legal in every state, with no stall or back-pressure.
- meta_done rises 1 cycle after the 0x00 key byte is accepted; busy falls on the same cycle.
- meta_error rises 1 cycle after the offending byte.
- String length counter is 8 bits and is cleared on entry to STRING.
- Reset asserted mid-token: immediate return to IDLE, all outputs 0. No pulse completes after reset deasserts.

## Test plan
- Full stream:
  - Stimulus: start, then "01 'Open Logic Sniffer v1.01' 00 02 '3.07' 00 21 00 00 60 00 23 0B EB C2 00 40 20 41 02 00".
  - Strings: 25+5 str_valid pulses, str_last on both terminators.
  - Registers: meta_sample_mem=0x00006000, meta_max_rate=0x0BEBC200, meta_probes=0x20, meta_protocol=0x02.
  - End: meta_done=1, busy=0.
- Unknown numeric keys:
  - Stimulus: start, "22 12 34 56 78 42 99 00".
  - Numeric: num_valid with 0x12345678, then 0x00000099.
  - Registers: all meta_* remain 0; meta_done=1.
- Bad type:
  - Stimulus: start, "60".
  - Response: meta_error=1 one cycle later. A following "00" leaves meta_done=0.
- String overflow, MAX_STR_LEN=4:
  - Stimulus: start, "01 41 42 43 44 45".
  - Response: 4 str_valid pulses, then meta_error=1, no 5th pulse.
  - Repeat with "01 41 42 43 44 00": 5 pulses, the last with str_last, no error.
- Abort:
  - Stimulus: start, "21 00 00", then start together with rx_valid=0x60, then "40 10 00".
  - Response: no num_valid for key 0x21, meta_error=0, meta_probes=0x10, meta_done=1.
- Reset mid-string:
  - Stimulus: extReset_n low for 1 cycle during a STRING token, asserted asynchronously between edges.
  - Response: all outputs 0 immediately; rx bytes are ignored until the next start.

Source files
------------

// File: rtl/meta_parser.sv
// Receive-side decoder for the SUMP/OLS metadata reply: splits the byte stream
// into string/numeric tokens and captures the well-known numeric keys.
`timescale 1ns/1ps
module meta_parser #(
  parameter int MAX_STR_LEN = 64
) (
  input  logic        clock,
  input  logic        extReset_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        busy,
  output logic        str_valid,
  output logic [7:0]  str_key,
  output logic [7:0]  str_byte,
  output logic        str_last,
  output logic        num_valid,
  output logic [7:0]  num_key,
  output logic [31:0] num_value,
  output logic [31:0] meta_sample_mem,
  output logic [31:0] meta_max_rate,
  output logic [7:0]  meta_probes,
  output logic [7:0]  meta_protocol,
  output logic        meta_done,
  output logic        meta_error
);

  typedef enum logic [2:0] {IDLE, KEY, STRING, LONG, SHORT, DONE, ERROR} state_t;

  localparam logic [7:0] MAX_LEN = 8'(MAX_STR_LEN);

  state_t      state;
  logic [7:0]  key;
  logic [7:0]  str_len;
  logic [1:0]  byte_cnt;
  logic [23:0] shift;
  logic        num_done;
  logic [31:0] num_next;

  // Value of the numeric token completed by the current byte, if any.
  always_comb begin
    num_next = {24'h0, rx_data};
    if (state == LONG) num_next = {shift, rx_data};
  end

  assign num_done = rx_valid && !start &&
                    ((state == SHORT) || ((state == LONG) && (byte_cnt == 2'd3)));

  // NOTE: every register here is sequential state, so all assignments are
  // non-blocking; a blocking write would let later reads see the new value.
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      state           <= IDLE;
      key             <= '0;
      str_len         <= '0;
      byte_cnt        <= '0;
      shift           <= '0;
      busy            <= 1'b0;
      str_valid       <= 1'b0;
      str_key         <= '0;
      str_byte        <= '0;
      str_last        <= 1'b0;
      num_valid       <= 1'b0;
      num_key         <= '0;
      num_value       <= '0;
      meta_sample_mem <= '0;
      meta_max_rate   <= '0;
      meta_probes     <= '0;
      meta_protocol   <= '0;
      meta_done       <= 1'b0;
      meta_error      <= 1'b0;
    end else begin
      str_valid <= 1'b0;
      str_last  <= 1'b0;
      num_valid <= 1'b0;

      if (start) begin
        // Abort whatever was in flight; partial tokens are simply dropped.
        state           <= KEY;
        busy            <= 1'b1;
        key             <= '0;
        str_len         <= '0;
        byte_cnt        <= '0;
        shift           <= '0;
        meta_sample_mem <= '0;
        meta_max_rate   <= '0;
        meta_probes     <= '0;
        meta_protocol   <= '0;
        meta_done       <= 1'b0;
        meta_error      <= 1'b0;
      end else if (rx_valid) begin
        case (state)
          KEY: begin
            if (rx_data[7:5] <= 3'b010) key <= rx_data;
            if (rx_data == 8'h00) begin
              state     <= DONE;
              meta_done <= 1'b1;
              busy      <= 1'b0;
            end else if (rx_data[7:5] == 3'b000) begin
              state   <= STRING;
              str_len <= '0;
            end else if (rx_data[7:5] == 3'b001) begin
              state    <= LONG;
              byte_cnt <= '0;
            end else if (rx_data[7:5] == 3'b010) begin
              state <= SHORT;
            end else begin
              state      <= ERROR;
              meta_error <= 1'b1;
              busy       <= 1'b0;
            end
          end
          STRING: begin
            if (rx_data == 8'h00) begin
              str_valid <= 1'b1;
              str_key   <= key;
              str_byte  <= 8'h00;
              str_last  <= 1'b1;
              state     <= KEY;
            end else if (str_len == MAX_LEN) begin
              state      <= ERROR;
              meta_error <= 1'b1;
              busy       <= 1'b0;
            end else begin
              str_valid <= 1'b1;
              str_key   <= key;
              str_byte  <= rx_data;
              str_len   <= str_len + 8'd1;
            end
          end
          LONG: begin
            shift    <= {shift[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) state <= KEY;
          end
          SHORT:   state <= KEY;
          default: ;
        endcase

        if (num_done) begin
          num_valid <= 1'b1;
          num_key   <= key;
          num_value <= num_next;
          case (key)
            8'h21:   meta_sample_mem <= num_next;
            8'h23:   meta_max_rate   <= num_next;
            8'h40:   meta_probes     <= num_next[7:0];
            8'h41:   meta_protocol   <= num_next[7:0];
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_meta_parser.sv
// Bench for meta_parser: two instances (long and 4-byte string limits) driven in
// parallel, checked against a token-level parser model of the metadata format.
`timescale 1ns/1ps
module tb_meta_parser;

  typedef logic [7:0] byte_t;
  typedef struct packed {
    logic        is_num;
    logic [7:0]  key;
    logic [31:0] val;
    logic        last;
  } ev_t;
  typedef struct {
    logic [31:0] sm;
    logic [31:0] mr;
    logic [7:0]  pr;
    logic [7:0]  pt;
    logic        done;
    logic        err;
    logic        busy;
  } fin_t;

  logic       clock = 1'b0;
  logic       extReset_n = 1'b0;
  logic       start = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic        busy_s[2], str_valid_s[2], str_last_s[2], num_valid_s[2];
  logic        meta_done_s[2], meta_error_s[2];
  logic [7:0]  str_key_s[2], str_byte_s[2], num_key_s[2];
  logic [7:0]  meta_probes_s[2], meta_protocol_s[2];
  logic [31:0] num_value_s[2], meta_sample_mem_s[2], meta_max_rate_s[2];

  always #5 clock = ~clock;

  meta_parser #(.MAX_STR_LEN(64)) dut_a (
    .clock(clock), .extReset_n(extReset_n), .start(start),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy_s[0]), .str_valid(str_valid_s[0]), .str_key(str_key_s[0]),
    .str_byte(str_byte_s[0]), .str_last(str_last_s[0]),
    .num_valid(num_valid_s[0]), .num_key(num_key_s[0]), .num_value(num_value_s[0]),
    .meta_sample_mem(meta_sample_mem_s[0]), .meta_max_rate(meta_max_rate_s[0]),
    .meta_probes(meta_probes_s[0]), .meta_protocol(meta_protocol_s[0]),
    .meta_done(meta_done_s[0]), .meta_error(meta_error_s[0])
  );

  meta_parser #(.MAX_STR_LEN(4)) dut_b (
    .clock(clock), .extReset_n(extReset_n), .start(start),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .busy(busy_s[1]), .str_valid(str_valid_s[1]), .str_key(str_key_s[1]),
    .str_byte(str_byte_s[1]), .str_last(str_last_s[1]),
    .num_valid(num_valid_s[1]), .num_key(num_key_s[1]), .num_value(num_value_s[1]),
    .meta_sample_mem(meta_sample_mem_s[1]), .meta_max_rate(meta_max_rate_s[1]),
    .meta_probes(meta_probes_s[1]), .meta_protocol(meta_protocol_s[1]),
    .meta_done(meta_done_s[1]), .meta_error(meta_error_s[1])
  );

  int    tests = 0;
  int    fails = 0;
  ev_t   act_q0[$], act_q1[$], exp_q0[$], exp_q1[$];
  byte_t seg_q[$];
  byte_t bq[$];
  bit    armed = 1'b0;
  fin_t  exp_fin[2];
  int    str_cnt[2], last_cnt[2], num_cnt[2];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic ev_t mk(input logic n, input logic [7:0] k, input logic [31:0] v,
                             input logic l);
    ev_t e;
    e.is_num = n;
    e.key    = k;
    e.val    = v;
    e.last   = l;
    return e;
  endfunction

  // Token monitor: records every pulse seen on each instance.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (str_valid_s[d]) begin
        str_cnt[d]++;
        if (str_last_s[d]) last_cnt[d]++;
        if (d == 0) act_q0.push_back(mk(1'b0, str_key_s[d], {24'h0, str_byte_s[d]}, str_last_s[d]));
        else        act_q1.push_back(mk(1'b0, str_key_s[d], {24'h0, str_byte_s[d]}, str_last_s[d]));
      end
      if (num_valid_s[d]) begin
        num_cnt[d]++;
        if (d == 0) act_q0.push_back(mk(1'b1, num_key_s[d], num_value_s[d], 1'b0));
        else        act_q1.push_back(mk(1'b1, num_key_s[d], num_value_s[d], 1'b0));
      end
    end
  end

  task automatic push_exp(input int d, input ev_t e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  function automatic fin_t zero_fin();
    fin_t f;
    f.sm = '0; f.mr = '0; f.pr = '0; f.pt = '0;
    f.done = 1'b0; f.err = 1'b0; f.busy = 1'b0;
    return f;
  endfunction

  // Reference parser: walks the bytes received since the last start token by token.
  task automatic model_run(input int d, input byte_t b[$], output fin_t f);
    int          i = 0;
    int          n = b.size();
    int          m = (d == 0) ? 64 : 4;
    int          len;
    bit          term;
    byte_t       k, c;
    logic [31:0] v;
    f = zero_fin();
    while (i < n && !f.done && !f.err) begin
      k = b[i]; i++;
      v = 'x;
      if (k == 8'h00) f.done = 1'b1;
      else if (k < 8'h20) begin
        len = 0; term = 1'b0;
        while (i < n && !term && !f.err) begin
          c = b[i]; i++;
          if (c == 8'h00) begin
            push_exp(d, mk(1'b0, k, 32'h0, 1'b1));
            term = 1'b1;
          end else if (len == m) f.err = 1'b1;
          else begin
            push_exp(d, mk(1'b0, k, {24'h0, c}, 1'b0));
            len++;
          end
        end
      end else if (k < 8'h40 || k < 8'h60) begin
        int w = (k < 8'h40) ? 4 : 1;
        if (i + w <= n) begin
          v = 32'h0;
          for (int j = 0; j < w; j++) v = (v << 8) | 32'(b[i + j]);
          i += w;
          push_exp(d, mk(1'b1, k, v, 1'b0));
          case (k)
            8'h21: f.sm = v;
            8'h23: f.mr = v;
            8'h40: f.pr = v[7:0];
            8'h41: f.pt = v[7:0];
            default: ;
          endcase
        end else i = n;
      end else f.err = 1'b1;
    end
    f.busy = !(f.done || f.err);
  endtask

  task automatic finalize_seg();
    if (armed) begin
      for (int d = 0; d < 2; d++) model_run(d, seg_q, exp_fin[d]);
    end
    seg_q.delete();
  endtask

  task automatic do_start(input bit with_byte, input byte_t b);
    finalize_seg();
    @(posedge clock); #1;
    start = 1'b1; rx_valid = with_byte; rx_data = b;
    @(posedge clock); #1;
    start = 1'b0; rx_valid = 1'b0;
    armed = 1'b1;
    for (int d = 0; d < 2; d++) begin
      str_cnt[d] = 0; last_cnt[d] = 0; num_cnt[d] = 0;
    end
  endtask

  task automatic feed(input byte_t bs[$], input int max_gap);
    foreach (bs[i]) begin
      repeat ($urandom_range(0, max_gap)) begin
        rx_valid = 1'b0; rx_data = 8'($urandom);
        @(posedge clock); #1;
      end
      rx_valid = 1'b1; rx_data = bs[i];
      if (armed) seg_q.push_back(bs[i]);
      @(posedge clock); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic cmp_ev(input string tag, input ev_t a[$], input ev_t e[$]);
    int n = (a.size() < e.size()) ? a.size() : e.size();
    check({tag, " token count"}, 64'(a.size()), 64'(e.size()));
    for (int i = 0; i < n; i++) check($sformatf("%s token%0d", tag, i), 64'(a[i]), 64'(e[i]));
  endtask

  task automatic finish_test(input string name);
    @(negedge clock); #1;
    finalize_seg();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s/%0d sample_mem", name, d), 64'(meta_sample_mem_s[d]), 64'(exp_fin[d].sm));
      check($sformatf("%s/%0d max_rate", name, d), 64'(meta_max_rate_s[d]), 64'(exp_fin[d].mr));
      check($sformatf("%s/%0d probes", name, d), 64'(meta_probes_s[d]), 64'(exp_fin[d].pr));
      check($sformatf("%s/%0d protocol", name, d), 64'(meta_protocol_s[d]), 64'(exp_fin[d].pt));
      check($sformatf("%s/%0d done", name, d), 64'(meta_done_s[d]), 64'(exp_fin[d].done));
      check($sformatf("%s/%0d error", name, d), 64'(meta_error_s[d]), 64'(exp_fin[d].err));
      check($sformatf("%s/%0d busy", name, d), 64'(busy_s[d]), 64'(exp_fin[d].busy));
    end
    cmp_ev({name, "/0"}, act_q0, exp_q0);
    cmp_ev({name, "/1"}, act_q1, exp_q1);
    act_q0.delete(); act_q1.delete(); exp_q0.delete(); exp_q1.delete();
  endtask

  task automatic chk_zero(input string tag, input int d);
    logic [63:0] all;
    all = {busy_s[d], str_valid_s[d], str_last_s[d], num_valid_s[d], meta_done_s[d],
           meta_error_s[d], 58'h0};
    check({tag, " flags"}, all, 64'h0);
    check({tag, " str"}, 64'({str_key_s[d], str_byte_s[d], num_key_s[d]}), 64'h0);
    check({tag, " num_value"}, 64'(num_value_s[d]), 64'h0);
    check({tag, " regs"}, {meta_sample_mem_s[d], meta_max_rate_s[d]}, 64'h0);
    check({tag, " regs8"}, 64'({meta_probes_s[d], meta_protocol_s[d]}), 64'h0);
  endtask

  task automatic add_str(input string s);
    for (int i = 0; i < s.len(); i++) bq.push_back(byte_t'(s[i]));
  endtask

  task automatic gen_stream();
    int r;
    byte_t k;
    bq.delete();
    repeat ($urandom_range(1, 6)) begin
      case ($urandom_range(0, 2))
        0: begin
          k = 8'($urandom_range(1, 31));
          bq.push_back(k);
          repeat (($urandom_range(0, 7) == 0) ? $urandom_range(60, 68) : $urandom_range(0, 6))
            bq.push_back(8'($urandom_range(1, 255)));
          bq.push_back(8'h00);
        end
        1: begin
          r = $urandom_range(0, 2);
          k = (r == 0) ? 8'h21 : (r == 1) ? 8'h23 : 8'($urandom_range(32, 63));
          bq.push_back(k);
          repeat (4) bq.push_back(8'($urandom));
        end
        default: begin
          r = $urandom_range(0, 2);
          k = (r == 0) ? 8'h40 : (r == 1) ? 8'h41 : 8'($urandom_range(64, 95));
          bq.push_back(k);
          bq.push_back(8'($urandom));
        end
      endcase
    end
    r = $urandom_range(0, 9);
    if (r < 6) bq.push_back(8'h00);
    else if (r < 8) bq.push_back(8'($urandom_range(96, 255)));
    repeat ($urandom_range(0, 2)) bq.push_back(8'($urandom));
  endtask

  initial begin
    exp_fin[0] = zero_fin();
    exp_fin[1] = zero_fin();
    for (int d = 0; d < 2; d++) begin
      str_cnt[d] = 0; last_cnt[d] = 0; num_cnt[d] = 0;
    end

    // Reset state
    #3;
    chk_zero("reset/0", 0);
    chk_zero("reset/1", 1);
    #9 extReset_n = 1'b1;
    @(posedge clock); #1;

    // Full metadata reply
    do_start(1'b0, 8'h00);
    bq = {8'h01};
    add_str("Open Logic Sniffer v1.01");
    bq = {bq, 8'h00, 8'h02};
    add_str("3.07");
    bq = {bq, 8'h00, 8'h21, 8'h00, 8'h00, 8'h60, 8'h00, 8'h23, 8'h0B, 8'hEB, 8'hC2, 8'h00,
          8'h40, 8'h20, 8'h41, 8'h02, 8'h00};
    feed(bq, 0);
    finish_test("full");
    check("full str pulses", 64'(str_cnt[0]), 64'd30);
    check("full str_last pulses", 64'(last_cnt[0]), 64'd2);
    check("full sample_mem", 64'(meta_sample_mem_s[0]), 64'h0000_6000);
    check("full max_rate", 64'(meta_max_rate_s[0]), 64'h0BEB_C200);
    check("full probes", 64'(meta_probes_s[0]), 64'h20);
    check("full protocol", 64'(meta_protocol_s[0]), 64'h02);
    check("full done/busy", 64'({meta_done_s[0], busy_s[0]}), 64'b10);

    // Unknown numeric keys, with pulse width check
    do_start(1'b0, 8'h00);
    bq = {8'h22, 8'h12, 8'h34, 8'h56, 8'h78};
    feed(bq, 0);
    @(negedge clock); #1;
    check("unk long pulse", 64'({num_valid_s[0], num_value_s[0]}), {31'h0, 1'b1, 32'h1234_5678});
    @(negedge clock); #1;
    check("unk pulse width", 64'(num_valid_s[0]), 64'h0);
    bq = {8'h42, 8'h99, 8'h00};
    feed(bq, 0);
    finish_test("unknown");
    check("unknown num pulses", 64'(num_cnt[0]), 64'd2);
    check("unknown regs", {meta_sample_mem_s[0], meta_max_rate_s[0]}, 64'h0);
    check("unknown done", 64'(meta_done_s[0]), 64'h1);

    // Bad type byte
    do_start(1'b0, 8'h00);
    bq = {8'h60};
    feed(bq, 0);
    @(negedge clock); #1;
    check("bad error latency", 64'({meta_error_s[0], busy_s[0]}), 64'b10);
    bq = {8'h00};
    feed(bq, 0);
    finish_test("badtype");
    check("bad done stays low", 64'(meta_done_s[0]), 64'h0);

    // String overflow against the 4-byte limit
    do_start(1'b0, 8'h00);
    bq = {8'h01, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    feed(bq, 0);
    finish_test("ovf");
    check("ovf pulses", 64'(str_cnt[1]), 64'd4);
    check("ovf error", 64'(meta_error_s[1]), 64'h1);
    do_start(1'b0, 8'h00);
    bq = {8'h01, 8'h41, 8'h42, 8'h43, 8'h44, 8'h00};
    feed(bq, 0);
    finish_test("fit");
    check("fit pulses", 64'(str_cnt[1]), 64'd5);
    check("fit last", 64'(last_cnt[1]), 64'd1);
    check("fit error", 64'(meta_error_s[1]), 64'h0);

    // Abort: start collides with a bad byte, which must be dropped
    do_start(1'b0, 8'h00);
    bq = {8'h21, 8'h00, 8'h00};
    feed(bq, 0);
    do_start(1'b1, 8'h60);
    bq = {8'h40, 8'h10, 8'h00};
    feed(bq, 0);
    finish_test("abort");
    check("abort num pulses", 64'(num_cnt[0]), 64'd1);
    check("abort state", 64'({meta_probes_s[0], meta_error_s[0], meta_done_s[0]}), {54'h0, 8'h10, 2'b01});

    // Asynchronous reset in the middle of a string
    do_start(1'b0, 8'h00);
    bq = {8'h01, 8'h41, 8'h42};
    feed(bq, 0);
    @(posedge clock); #3;
    finalize_seg();
    armed = 1'b0;
    exp_fin[0] = zero_fin();
    exp_fin[1] = zero_fin();
    extReset_n = 1'b0;
    #1;
    chk_zero("midreset/0", 0);
    chk_zero("midreset/1", 1);
    @(posedge clock); #3;
    extReset_n = 1'b1;
    @(posedge clock); #1;
    bq = {8'h22, 8'h01, 8'h02, 8'h03, 8'h04, 8'h40, 8'h05, 8'h00};
    feed(bq, 0);
    finish_test("postreset");

    // Randomized streams with idle gaps
    for (int t = 0; t < 25; t++) begin
      do_start($urandom_range(0, 3) == 0, 8'($urandom));
      gen_stream();
      feed(bq, 2);
      finish_test($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
